// File: rtl/rs_pkg.sv
// Shared types, default widths and helpers for the parametrised reservation station.
package rs_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_TAG_W  = 5;
    localparam int unsigned DEF_OP_W   = 5;

    // A producer label of zero means the operand value is already present.
    localparam int unsigned TAG_NONE = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef struct packed {
        logic                  busy;
        logic [DEF_OP_W-1:0]   op;
        logic [DEF_OP_W-1:0]   func;
        logic [DEF_DATA_W-1:0] vj;
        logic [DEF_TAG_W-1:0]  qj;
        logic [DEF_DATA_W-1:0] vk;
        logic [DEF_TAG_W-1:0]  qk;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_picker.sv
// Age matrix for the reservation station: tracks issue order and grants the oldest ready entry.
module rs_age_picker #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [DEPTH-1:0] busy_i,
    input  logic [DEPTH-1:0] ready_i,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    output logic [DEPTH-1:0] grant_o
);

    // age_q[i][j] set means entry j was issued before entry i and is still busy.
    logic [DEPTH-1:0][DEPTH-1:0] age_q;
    logic [DEPTH-1:0][DEPTH-1:0] age_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i] & ~free_i;
            if (alloc_i[i]) begin
                age_d[i] = busy_i & ~free_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = ready_i[i] && !(|(age_q[i] & ready_i));
        end
    end

endmodule

// File: rtl/rs_param_station.sv
// Parametrised Tomasulo reservation station: issue with CDB capture, CDB snoop,
// oldest-ready dispatch to one functional unit, and flush.
module rs_param_station
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned OP_W   = DEF_OP_W,
    parameter int unsigned RS_ID  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OP_W-1:0]               in_op,
    input  logic [OP_W-1:0]               in_func,
    input  logic [DATA_W-1:0]             in_data1,
    input  logic [TAG_W-1:0]              in_label1,
    input  logic [DATA_W-1:0]             in_data2,
    input  logic [TAG_W-1:0]              in_label2,
    input  logic                          bc_en,
    input  logic [TAG_W-1:0]              bc_label,
    input  logic [DATA_W-1:0]             bc_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OP_W-1:0]               out_op,
    output logic [OP_W-1:0]               out_func,
    output logic [DATA_W-1:0]             out_data1,
    output logic [DATA_W-1:0]             out_data2,
    output logic [TAG_W-1:0]              labelOut,
    output logic                          full,
    output logic [clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned IDX_W = clog2(DEPTH);
    localparam int unsigned CNT_W = clog2(DEPTH+1);
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

    // Same layout as rs_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [OP_W-1:0]   func;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
    } entry_t;

    entry_t            entry_q [DEPTH];
    entry_t            entry_d [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  alloc;
    logic [DEPTH-1:0]  grant;
    logic              alloc_found;
    logic              issue_fire;
    logic              disp_fire;
    logic              bc_hit;
    logic              cap1;
    logic              cap2;
    logic [IDX_W-1:0]  sel_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy[i]  = entry_q[i].busy;
            ready[i] = entry_q[i].busy && (entry_q[i].qj == NO_TAG) && (entry_q[i].qk == NO_TAG);
        end
    end

    always_comb begin
        alloc       = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !alloc_found) begin
                alloc[i]    = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    assign full       = &busy;
    assign in_ready   = !full;
    assign out_valid  = |ready;
    assign issue_fire = in_valid && in_ready;
    assign disp_fire  = out_valid && out_ready;
    assign bc_hit     = bc_en && (bc_label != NO_TAG);
    // An operand whose producer broadcasts in the issue cycle is captured directly.
    assign cap1       = bc_hit && (bc_label == in_label1);
    assign cap2       = bc_hit && (bc_label == in_label2);

    rs_age_picker #(
        .DEPTH (DEPTH)
    ) u_age_picker (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (flush),
        .busy_i  (busy),
        .ready_i (ready),
        .alloc_i (alloc & {DEPTH{issue_fire}}),
        .free_i  (grant & {DEPTH{disp_fire}}),
        .grant_o (grant)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].busy && bc_hit) begin
                if (entry_q[i].qj == bc_label) begin
                    entry_d[i].vj = bc_data;
                    entry_d[i].qj = NO_TAG;
                end
                if (entry_q[i].qk == bc_label) begin
                    entry_d[i].vk = bc_data;
                    entry_d[i].qk = NO_TAG;
                end
            end
            if (disp_fire && grant[i]) begin
                entry_d[i].busy = 1'b0;
            end
            if (issue_fire && alloc[i]) begin
                entry_d[i].busy = 1'b1;
                entry_d[i].op   = in_op;
                entry_d[i].func = in_func;
                entry_d[i].vj   = cap1 ? bc_data : in_data1;
                entry_d[i].qj   = cap1 ? NO_TAG : in_label1;
                entry_d[i].vk   = cap2 ? bc_data : in_data2;
                entry_d[i].qk   = cap2 ? NO_TAG : in_label2;
            end
        end
    end

    assign count_d = count_q + CNT_W'(issue_fire) - CNT_W'(disp_fire);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q <= count_d;
        end
    end

    assign count = count_q;

    always_comb begin
        out_op    = '0;
        out_func  = '0;
        out_data1 = '0;
        out_data2 = '0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                out_op    = entry_q[i].op;
                out_func  = entry_q[i].func;
                out_data1 = entry_q[i].vj;
                out_data2 = entry_q[i].vk;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign labelOut = out_valid ? (TAG_W'(RS_ID << IDX_W) | TAG_W'(sel_idx)) : '0;

endmodule

// File: tb/tb_rs_param_station.sv
// Directed bench for rs_param_station; dispatches are checked against a queue of expected results.
module tb_rs_param_station;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned RS_ID  = 1;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready;
    logic [OP_W-1:0]   in_op, in_func;
    logic [DATA_W-1:0] in_data1, in_data2;
    logic [TAG_W-1:0]  in_label1, in_label2;
    logic              bc_en;
    logic [TAG_W-1:0]  bc_label;
    logic [DATA_W-1:0] bc_data;
    logic              out_valid, out_ready;
    logic [OP_W-1:0]   out_op, out_func;
    logic [DATA_W-1:0] out_data1, out_data2;
    logic [TAG_W-1:0]  labelOut;
    logic              full;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [OP_W-1:0]   func;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [TAG_W-1:0]  lbl;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    rs_param_station #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .OP_W   (OP_W),
        .RS_ID  (RS_ID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_func   (in_func),
        .in_data1  (in_data1),
        .in_label1 (in_label1),
        .in_data2  (in_data2),
        .in_label2 (in_label2),
        .bc_en     (bc_en),
        .bc_label  (bc_label),
        .bc_data   (bc_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_func  (out_func),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .labelOut  (labelOut),
        .full      (full),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change only 2 time units after a rising edge; the monitor samples on the falling edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [OP_W-1:0] func,
                         input logic [DATA_W-1:0] d1, input logic [TAG_W-1:0] l1,
                         input logic [DATA_W-1:0] d2, input logic [TAG_W-1:0] l2);
        in_valid  = 1'b1;
        in_op     = op;
        in_func   = func;
        in_data1  = d1;
        in_label1 = l1;
        in_data2  = d2;
        in_label2 = l2;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic bcast(input logic [TAG_W-1:0] lbl, input logic [DATA_W-1:0] data);
        bc_en    = 1'b1;
        bc_label = lbl;
        bc_data  = data;
        tick();
        bc_en    = 1'b0;
    endtask

    task automatic push(input logic [OP_W-1:0] op, input logic [OP_W-1:0] func,
                        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                        input logic [TAG_W-1:0] lbl);
        exp_t e;
        e.op   = op;
        e.func = func;
        e.d1   = d1;
        e.d2   = d2;
        e.lbl  = lbl;
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            exp_t e;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_dispatch: observed label 0x%0h expected no dispatch",
                       labelOut);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("disp_op", 64'(out_op), 64'(e.op));
                chk("disp_func", 64'(out_func), 64'(e.func));
                chk("disp_data1", 64'(out_data1), 64'(e.d1));
                chk("disp_data2", 64'(out_data2), 64'(e.d2));
                chk("disp_label", 64'(labelOut), 64'(e.lbl));
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bc_en = 1'b0;
        in_op = '0; in_func = '0; in_data1 = '0; in_data2 = '0; in_label1 = '0; in_label2 = '0;
        bc_label = '0; bc_data = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data1", 64'(out_data1), 64'd0);
        chk("rst_label", 64'(labelOut), 64'd0);

        // Both operands ready: presented the cycle after issue.
        issue(5'd3, 5'd1, 32'd10, 5'd0, 32'd20, 5'd0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_op", 64'(out_op), 64'd3);
        chk("t1_data1", 64'(out_data1), 64'd10);
        chk("t1_data2", 64'(out_data2), 64'd20);
        chk("t1_label", 64'(labelOut), 64'd4);
        chk("t1_count", 64'(count), 64'd1);
        push(5'd3, 5'd1, 32'd10, 32'd20, 5'd4);
        dispatch(1);
        chk("t1_count_after", 64'(count), 64'd0);
        chk("t1_valid_after", 64'(out_valid), 64'd0);

        // Operand 1 waits on tag 7, then a broadcast wakes it.
        issue(5'd4, 5'd2, 32'h111, 5'd7, 32'd5, 5'd0);
        chk("t2_wait", 64'(out_valid), 64'd0);
        bcast(5'd7, 32'hDEAD);
        chk("t2_woken", 64'(out_valid), 64'd1);
        chk("t2_data1", 64'(out_data1), 64'hDEAD);
        push(5'd4, 5'd2, 32'hDEAD, 32'd5, 5'd4);
        dispatch(1);

        // Broadcast in the issue cycle is captured directly.
        bc_en = 1'b1; bc_label = 5'd9; bc_data = 32'd55;
        issue(5'd5, 5'd3, 32'd1, 5'd0, 32'h222, 5'd9);
        bc_en = 1'b0;
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_data2", 64'(out_data2), 64'd55);
        push(5'd5, 5'd3, 32'd1, 32'd55, 5'd4);
        dispatch(1);

        // Fill, free two, refill so that index order and age order disagree.
        issue(5'd7, 5'd1, 32'd1, 5'd0, 32'd2, 5'd0);
        issue(5'd8, 5'd1, 32'd3, 5'd0, 32'd4, 5'd0);
        issue(5'd9, 5'd2, 32'd0, 5'd12, 32'd5, 5'd0);
        issue(5'd10, 5'd2, 32'd6, 5'd0, 32'd0, 5'd13);
        chk("t4_full", 64'(full), 64'd1);
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        chk("t4_count", 64'(count), 64'd4);
        chk("t4_first_label", 64'(labelOut), 64'd4);
        push(5'd7, 5'd1, 32'd1, 32'd2, 5'd4);
        push(5'd8, 5'd1, 32'd3, 32'd4, 5'd5);
        dispatch(2);
        chk("t4_count_two", 64'(count), 64'd2);
        chk("t4_none_ready", 64'(out_valid), 64'd0);
        issue(5'd11, 5'd3, 32'd0, 5'd11, 32'd8, 5'd0);
        issue(5'd12, 5'd3, 32'd9, 5'd0, 32'd0, 5'd14);
        chk("t4_refill_count", 64'(count), 64'd4);
        issue(5'd13, 5'd0, 32'd1, 5'd0, 32'd1, 5'd0);
        chk("t4_fifth_ignored", 64'(count), 64'd4);
        chk("t4_still_full", 64'(full), 64'd1);
        bcast(5'd12, 32'h100);
        chk("t4_e2_ready", 64'(labelOut), 64'd6);
        bcast(5'd11, 32'h200);
        chk("t4_e2_older", 64'(labelOut), 64'd6);
        push(5'd9, 5'd2, 32'h100, 32'd5, 5'd6);
        dispatch(1);
        chk("t4_e0_next", 64'(labelOut), 64'd4);
        bcast(5'd14, 32'h300);
        chk("t4_e0_holds", 64'(labelOut), 64'd4);
        push(5'd11, 5'd3, 32'h200, 32'd8, 5'd4);
        dispatch(1);
        chk("t4_e1_alone", 64'(labelOut), 64'd5);
        bcast(5'd13, 32'h400);
        chk("t4_e3_preempts", 64'(labelOut), 64'd7);
        push(5'd10, 5'd2, 32'd6, 32'h400, 5'd7);
        push(5'd12, 5'd3, 32'd9, 32'h300, 5'd5);
        dispatch(2);
        chk("t4_drained", 64'(count), 64'd0);

        // Full station: dispatch and issue together refuse the issue.
        issue(5'd20, 5'd0, 32'd20, 5'd0, 32'd21, 5'd0);
        issue(5'd21, 5'd0, 32'd22, 5'd0, 32'd23, 5'd0);
        issue(5'd22, 5'd0, 32'd24, 5'd0, 32'd25, 5'd0);
        issue(5'd23, 5'd0, 32'd26, 5'd0, 32'd27, 5'd0);
        chk("t5_full", 64'(full), 64'd1);
        push(5'd20, 5'd0, 32'd20, 32'd21, 5'd4);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 5'd24; in_func = 5'd0;
        in_data1 = 32'd28; in_label1 = 5'd0; in_data2 = 32'd29; in_label2 = 5'd0;
        tick();
        out_ready = 1'b0;
        chk("t5_refused_count", 64'(count), 64'd3);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t5_accepted_count", 64'(count), 64'd4);
        chk("t5_full_again", 64'(full), 64'd1);
        push(5'd21, 5'd0, 32'd22, 32'd23, 5'd5);
        push(5'd22, 5'd0, 32'd24, 32'd25, 5'd6);
        push(5'd23, 5'd0, 32'd26, 32'd27, 5'd7);
        push(5'd24, 5'd0, 32'd28, 32'd29, 5'd4);
        dispatch(4);
        chk("t5_drained", 64'(count), 64'd0);

        // Flush beats a simultaneous broadcast and issue.
        issue(5'd26, 5'd0, 32'd0, 5'd20, 32'd1, 5'd0);
        issue(5'd27, 5'd0, 32'd0, 5'd21, 32'd1, 5'd0);
        issue(5'd28, 5'd0, 32'd0, 5'd22, 32'd1, 5'd0);
        chk("t6_count3", 64'(count), 64'd3);
        flush = 1'b1;
        bc_en = 1'b1; bc_label = 5'd20; bc_data = 32'h77;
        in_valid = 1'b1; in_op = 5'd29; in_func = 5'd0;
        in_data1 = 32'd1; in_label1 = 5'd0; in_data2 = 32'd1; in_label2 = 5'd0;
        tick();
        flush = 1'b0; bc_en = 1'b0; in_valid = 1'b0;
        chk("t6_count0", 64'(count), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_full", 64'(full), 64'd0);
        issue(5'd30, 5'd1, 32'd0, 5'd20, 32'd2, 5'd0);
        chk("t6_no_stale_bc", 64'(out_valid), 64'd0);
        bcast(5'd20, 32'h99);
        chk("t6_woken", 64'(out_valid), 64'd1);
        chk("t6_data1", 64'(out_data1), 64'h99);
        chk("t6_label", 64'(labelOut), 64'd4);
        push(5'd30, 5'd1, 32'h99, 32'd2, 5'd4);
        dispatch(1);
        chk("t6_drained", 64'(count), 64'd0);

        tick();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
